// File: rtl/fix_field_tokenizer.sv
// fix_field_tokenizer: splits a raw FIX byte stream into tag / value / field-end
// tokens and checks the tag 10 trailer against a running modulo-256 byte sum.
// Build option: define FIX_CKSUM_EN to build the checksum datapath; without it
// cksum_ok is tied to 1 and msg_end still marks closure of a tag 10 field.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_TAG   | accumulating decimal tag digits until '='
// S_VALUE | forwarding value bytes until the delimiter
// S_SKIP  | discarding the rest of a malformed field until the delimiter
module fix_field_tokenizer #(
  parameter logic [7:0] DELIM = 8'h01,
  parameter int         TAG_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  input  logic             out_ready,
  output logic             tag_valid,
  output logic [TAG_W-1:0] tag,
  output logic             val_valid,
  output logic [7:0]       val_data,
  output logic             field_end,
  output logic             field_err,
  output logic             msg_end,
  output logic             cksum_ok
);

  localparam int         TW = TAG_W + 4;
  localparam logic [7:0] EQ = 8'h3D;

  typedef enum logic [1:0] {S_TAG, S_VALUE, S_SKIP} state_t;

  state_t           state;
  logic [TAG_W-1:0] tag_acc;
  logic             tag_first;   // next TAG-state byte is the first of a field
  logic             is_ck;       // current field is tag 10
  logic             is_digit;
  logic             is_delim;
  logic [3:0]       digit;
  logic [TW-1:0]    tag_wide;
  logic             tag_ovf;

  // the whole block stalls with the downstream; no skid buffer
  assign in_ready = out_ready;
  assign is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
  assign is_delim = (in_data == DELIM);
  assign digit    = in_data[3:0];
  // four spare bits hold tag_acc*10+9 without wrapping, so overflow is exact
  assign tag_wide = ({4'b0000, tag_acc} * TW'(10)) + TW'(digit);
  assign tag_ovf  = |tag_wide[TW-1:TAG_W];

  // tokenizer FSM and registered token pulses; nothing moves while out_ready=0
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_TAG;
      tag_acc   <= '0;
      tag_first <= 1'b1;
      is_ck     <= 1'b0;
      tag_valid <= 1'b0;
      tag       <= '0;
      val_valid <= 1'b0;
      val_data  <= 8'h00;
      field_end <= 1'b0;
      field_err <= 1'b0;
      msg_end   <= 1'b0;
    end else if (out_ready) begin
      tag_valid <= 1'b0;
      val_valid <= 1'b0;
      field_end <= 1'b0;
      field_err <= 1'b0;
      msg_end   <= 1'b0;
      if (in_valid) begin
        case (state)
          S_TAG: begin
            tag_first <= 1'b0;
            if (is_digit && !tag_ovf) begin
              tag_acc <= tag_wide[TAG_W-1:0];
            end else if (in_data == EQ && !tag_first) begin
              tag_valid <= 1'b1;
              tag       <= tag_acc;
              is_ck     <= (tag_acc == TAG_W'(10));
              tag_acc   <= '0;
              state     <= S_VALUE;
            end else begin
              // bad digit, empty tag, overflow or premature delimiter
              field_err <= 1'b1;
              tag_acc   <= '0;
              if (is_delim) begin
                tag_first <= 1'b1;
              end else begin
                state <= S_SKIP;
              end
            end
          end
          S_VALUE: begin
            if (!is_delim) begin
              val_valid <= 1'b1;
              val_data  <= in_data;
            end else begin
              field_end <= 1'b1;
              msg_end   <= is_ck;
              tag_acc   <= '0;
              tag_first <= 1'b1;
              state     <= S_TAG;
            end
          end
          default: begin
            if (is_delim) begin
              tag_first <= 1'b1;
              state     <= S_TAG;
            end
          end
        endcase
      end
    end
  end

`ifdef FIX_CKSUM_EN
  logic [7:0] sum;
  logic [7:0] field_sum;
  logic [9:0] ck_val;
  logic [1:0] ck_cnt;
  logic       ck_bad;
  logic       cksum_q;
  logic       close_ck;

  assign close_ck = in_valid && (state == S_VALUE) && is_delim && is_ck;

  // running byte sum, per-field snapshot and decimal decode of the tag 10 value
  always_ff @(posedge clk) begin
    if (reset) begin
      sum       <= 8'h00;
      field_sum <= 8'h00;
      ck_val    <= 10'd0;
      ck_cnt    <= 2'd0;
      ck_bad    <= 1'b0;
      cksum_q   <= 1'b0;
    end else if (out_ready) begin
      cksum_q <= 1'b0;
      if (in_valid) begin
        // the trailer's own closing delimiter starts the next message at zero
        sum <= close_ck ? 8'h00 : sum + in_data;
        if (state == S_TAG && tag_first) begin
          field_sum <= sum;
        end
        if (state == S_TAG && in_data == EQ && !tag_first) begin
          ck_val <= 10'd0;
          ck_cnt <= 2'd0;
          ck_bad <= 1'b0;
        end
        if (state == S_VALUE && is_ck && !is_delim) begin
          if (is_digit && ck_cnt != 2'd3) begin
            ck_val <= (ck_val * 10'd10) + {6'b000000, digit};
            ck_cnt <= ck_cnt + 2'd1;
          end else begin
            ck_bad <= 1'b1;
          end
        end
        if (close_ck) begin
          cksum_q <= !ck_bad && (ck_val == {2'b00, field_sum});
        end
      end
    end
  end

  assign cksum_ok = cksum_q;
`else
  assign cksum_ok = 1'b1;
`endif

endmodule

// File: tb/tb_fix_field_tokenizer.sv
// Self-checking bench for fix_field_tokenizer. Expected tokens are queued as
// stimulus is driven; a negedge monitor pops and compares each output pulse.
// '|' in stimulus strings stands for the delimiter byte.
module tb_fix_field_tokenizer;

  localparam logic [7:0] DELIM = 8'h01;
  localparam int         TAG_W = 16;
  localparam int K_TAG = 0, K_VAL = 1, K_ERR = 2, K_FEND = 3, K_MEND = 4;
`ifdef FIX_CKSUM_EN
  localparam int CK_EN = 1;
`else
  localparam int CK_EN = 0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             out_ready;
  logic             tag_valid;
  logic [TAG_W-1:0] tag;
  logic             val_valid;
  logic [7:0]       val_data;
  logic             field_end;
  logic             field_err;
  logic             msg_end;
  logic             cksum_ok;

  typedef struct {
    int kind;
    int val;
  } ev_t;

  ev_t   sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  logic  fresh    = 1'b0;
  string knames[5] = '{"tag", "val", "err", "fend", "mend"};

  fix_field_tokenizer #(.DELIM(DELIM), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_ready(out_ready), .tag_valid(tag_valid),
    .tag(tag), .val_valid(val_valid), .val_data(val_data),
    .field_end(field_end), .field_err(field_err), .msg_end(msg_end),
    .cksum_ok(cksum_ok)
  );

  always #5 clk = ~clk;

  // outputs are newly produced only after an edge that was not stalled
  always @(posedge clk) fresh <= out_ready && !reset;

  // scoreboard monitor
  always @(negedge clk) begin
    logic [4:0] p;
    int         obs[5];
    ev_t        e;
    if (fresh) begin
      p = {msg_end, field_end, field_err, val_valid, tag_valid};
      obs[0] = int'(tag);
      obs[1] = int'(val_data);
      obs[2] = 0;
      obs[3] = 0;
      obs[4] = int'(cksum_ok);
      for (int k = 0; k < 5; k++) begin
        if (p[k]) begin
          n_checks++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got %s value %0d, required no event", knames[k], obs[k]);
          end else begin
            e = sb.pop_front();
            if (e.kind != k || ((k == K_TAG || k == K_VAL || k == K_MEND) && e.val != obs[k])) begin
              n_fail++;
              $display("FAIL sb_event: got %s value %0d, required %s value %0d",
                       knames[k], obs[k], knames[e.kind], e.val);
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic push(input int k, input int v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      in_valid = 1'b1;
      in_data  = (s[i] == "|") ? DELIM : s[i];
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_%s: got %0d expected events never produced, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_idle_outputs(input string name);
    n_checks++;
    if ({tag_valid, val_valid, field_end, field_err, msg_end} !== 5'b0 || tag !== '0 ||
        val_data !== 8'h00 || cksum_ok !== (CK_EN ? 1'b0 : 1'b1)) begin
      n_fail++;
      $display("FAIL %s: got pulses=%b tag=%0d val=%h ok=%b, required pulses=0 tag=0 val=00 ok=%0d",
               name, {tag_valid, val_valid, field_end, field_err, msg_end}, tag, val_data,
               cksum_ok, CK_EN ? 0 : 1);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_idle_outputs("reset_values");
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    push(K_TAG, 35); push(K_VAL, 8'h41); push(K_FEND, 0);
    send_str("35=");
    n_checks++;
    if (tag_valid !== 1'b1 || tag !== 16'd35 || field_err !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_tag_latency: got tag_valid=%b tag=%0d err=%b, required 1 35 0",
               tag_valid, tag, field_err);
    end
    send_str("A|");
    drain("basic");
  endtask

  task automatic test_stall();
    push(K_TAG, 12); push(K_VAL, 8'h51); push(K_FEND, 0);
    send_str("12=");
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h51;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0 || tag_valid !== 1'b1 || tag !== 16'd12 || val_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got in_ready=%b tag_valid=%b tag=%0d val_valid=%b, required 0 1 12 0",
                 i, in_ready, tag_valid, tag, val_valid);
      end
    end
    out_ready = 1'b1;
    send_str("Q|");
    drain("stall");
  endtask

  task automatic test_errors();
    push(K_ERR, 0); push(K_TAG, 8); push(K_VAL, 8'h46); push(K_FEND, 0);
    send_str("3A");
    n_checks++;
    if (field_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_latency: got field_err=%b, required 1", field_err);
    end
    send_str("=5|8=F|");
    push(K_ERR, 0); push(K_TAG, 9); push(K_VAL, 8'h5A); push(K_FEND, 0);
    send_str("=5|9=Z|");
    push(K_ERR, 0); push(K_TAG, 7); push(K_VAL, 8'h71); push(K_FEND, 0);
    send_str("70000=1|7=q|");
    push(K_TAG, 65535); push(K_VAL, 8'h6B); push(K_FEND, 0);
    send_str("65535=k|");
    push(K_ERR, 0); push(K_TAG, 5); push(K_VAL, 8'h78); push(K_FEND, 0);
    send_str("4|5=x|");
    drain("errors");
  endtask

  task automatic test_back_to_back();
    push(K_TAG, 1); push(K_VAL, 8'h78); push(K_VAL, 8'h79); push(K_FEND, 0);
    push(K_TAG, 22); push(K_VAL, 8'h7A); push(K_FEND, 0);
    send_str("1=xy|22=z|");
    drain("back_to_back");
  endtask

  task automatic push_cksum_msg(input string v, input int ok);
    push(K_TAG, 35); push(K_VAL, 8'h30); push(K_FEND, 0);
    push(K_TAG, 10);
    for (int i = 0; i < v.len(); i++) push(K_VAL, int'(v[i]));
    push(K_FEND, 0);
    push(K_MEND, ok);
  endtask

  task automatic test_cksum();
    do_reset();
    // "35=0|" sums to 0xD6 = 214
    push_cksum_msg("214", 1);
    send_str("35=0|10=214|");
    push_cksum_msg("215", CK_EN ? 0 : 1);
    send_str("35=0|10=215|");
    push_cksum_msg("2x4", CK_EN ? 0 : 1);
    send_str("35=0|10=2x4|");
    drain("cksum");
  endtask

  task automatic test_reset_mid();
    push(K_TAG, 12); push(K_VAL, 8'h61); push(K_VAL, 8'h62);
    send_str("12=ab");
    @(posedge clk);
    #1;
    do_reset();
    check_idle_outputs("reset_mid_values");
    push(K_TAG, 10); push(K_VAL, 8'h30); push(K_VAL, 8'h30); push(K_VAL, 8'h30);
    push(K_FEND, 0); push(K_MEND, 1);
    send_str("10=000|");
    drain("reset_mid");
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_errors();
    test_back_to_back();
    test_cksum();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
